// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port and control-unit issue handshake of the sequencer.
// master = sequencer side, slave = memory / control-unit side.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
);
    logic [ADDR_BITS-1:0]   imem_addr;
    logic                   imem_re;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   cu_ready;

    modport master (
        output imem_addr, imem_re, instr, instr_valid,
        input  imem_data, cu_ready
    );

    modport slave (
        input  imem_addr, imem_re, instr, instr_valid,
        output imem_data, cu_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: reads one word per instruction, holds it for the CU until accepted, stops on a halt word.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input and a STEP state that pauses after every non-halt instruction.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step,
`endif
    instr_sequencer_if.master    bus,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
        , STEP = 3'd5
`endif
    } state_t;

    localparam logic [ADDR_BITS-1:0]   PC_ZERO    = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0]   PC_ONE     = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [INSTR_WIDTH-1:0] INSTR_ZERO = {INSTR_WIDTH{1'b0}};

    // A word whose two top opcode bits are zero terminates the program.
    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
        return (word[INSTR_WIDTH-1 -: 2] == 2'b00);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [ADDR_BITS-1:0]   pc_r, pc_nxt_s;
    logic [ADDR_BITS-1:0]   imem_addr_r, imem_addr_nxt_s;
    logic                   imem_re_r, imem_re_nxt_s;
    logic [INSTR_WIDTH-1:0] instr_r, instr_nxt_s;
    logic                   instr_valid_r, instr_valid_nxt_s;
    logic                   halted_r, halted_nxt_s;
    logic [CNT_WIDTH-1:0]   retired_r, retired_nxt_s;

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            pc_r          <= PC_ZERO;
            imem_addr_r   <= PC_ZERO;
            imem_re_r     <= 1'b0;
            instr_r       <= INSTR_ZERO;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            retired_r     <= CNT_ZERO;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            imem_addr_r   <= imem_addr_nxt_s;
            imem_re_r     <= imem_re_nxt_s;
            instr_r       <= instr_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
            halted_r      <= halted_nxt_s;
            retired_r     <= retired_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, HALTED: begin
                if (start) state_nxt_s = FETCH;
                else       state_nxt_s = state_r;
            end
            FETCH: state_nxt_s = WAIT;
            WAIT:  state_nxt_s = ISSUE;
            ISSUE: begin
                if (!bus.cu_ready)         state_nxt_s = ISSUE;
                else if (is_halt(instr_r)) state_nxt_s = HALTED;
`ifdef SEQ_SINGLE_STEP_EN
                else                       state_nxt_s = STEP;
`else
                else                       state_nxt_s = FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            STEP: begin
                if (step) state_nxt_s = FETCH;
                else      state_nxt_s = STEP;
            end
`endif
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: the values the output flops load at the coming edge, so the
    // read strobe is already up during the FETCH cycle itself.
    always_comb begin
        pc_nxt_s          = pc_r;
        imem_addr_nxt_s   = imem_addr_r;
        imem_re_nxt_s     = 1'b0;
        instr_nxt_s       = instr_r;
        instr_valid_nxt_s = 1'b0;
        halted_nxt_s      = halted_r;
        retired_nxt_s     = retired_r;
        case (state_r)
            IDLE, HALTED: begin
                if (start) begin
                    pc_nxt_s        = PC_ZERO;
                    imem_addr_nxt_s = PC_ZERO;
                    imem_re_nxt_s   = 1'b1;
                    halted_nxt_s    = 1'b0;
                    retired_nxt_s   = CNT_ZERO;
                end else begin
                    imem_re_nxt_s   = 1'b0;
                end
            end
            FETCH: imem_re_nxt_s = 1'b0;
            WAIT: begin
                instr_nxt_s       = bus.imem_data;
                instr_valid_nxt_s = 1'b1;
            end
            ISSUE: begin
                if (bus.cu_ready) begin
                    retired_nxt_s = sat_inc(retired_r);
                    if (is_halt(instr_r)) begin
                        halted_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
`ifndef SEQ_SINGLE_STEP_EN
                        imem_addr_nxt_s = pc_r + PC_ONE;
                        imem_re_nxt_s   = 1'b1;
`endif
                    end
                end else begin
                    instr_valid_nxt_s = 1'b1;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            STEP: begin
                if (step) begin
                    imem_addr_nxt_s = pc_r;
                    imem_re_nxt_s   = 1'b1;
                end else begin
                    imem_re_nxt_s   = 1'b0;
                end
            end
`endif
            default: imem_re_nxt_s = 1'b0;
        endcase
    end

    assign bus.imem_addr   = imem_addr_r;
    assign bus.imem_re     = imem_re_r;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = instr_valid_r;
    assign pc              = pc_r;
    assign halted          = halted_r;
    assign retired         = retired_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model (cycles since the last fetch trigger, current pc, retire count).
module tb_instr_sequencer;
    localparam int IW = 20;
    localparam int AB = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step = 1'b0;
`endif
    logic [AB-1:0] pc;
    logic          halted;
    logic [CW-1:0] retired;

    instr_sequencer_if #(.INSTR_WIDTH(IW), .ADDR_BITS(AB)) bus();

    instr_sequencer #(.INSTR_WIDTH(IW), .ADDR_BITS(AB), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step    (step),
`endif
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [32];
    int n_tests = 0;
    int n_fail  = 0;
    int hs_count = 0;
    logic [IW-1:0] acc_q [$];

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst)             bus.imem_data <= '0;
        else if (bus.imem_re) bus.imem_data <= rom[bus.imem_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: active run, cycles since the fetch trigger, pc, retired count.
    bit m_active, m_stepwait, m_halted;
    int m_age, m_pc, m_ret;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0; m_stepwait <= 1'b0; m_halted <= 1'b0;
            m_age <= 0; m_pc <= 0; m_ret <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1; m_age <= 1; m_pc <= 0; m_ret <= 0; m_halted <= 1'b0;
            end
        end
`ifdef SEQ_SINGLE_STEP_EN
        else if (m_stepwait) begin
            if (step) begin
                m_stepwait <= 1'b0; m_age <= 1;
            end
        end
`endif
        else if (m_age >= 3 && bus.cu_ready) begin
            m_ret <= (m_ret >= 255) ? 255 : m_ret + 1;
            if (rom[m_pc][19:18] == 2'b00) begin
                m_halted <= 1'b1; m_active <= 1'b0;
            end else begin
                m_pc <= (m_pc + 1) % 32;
`ifdef SEQ_SINGLE_STEP_EN
                m_stepwait <= 1'b1;
`else
                m_age <= 1;
`endif
            end
        end else if (m_age < 1000) begin
            m_age <= m_age + 1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit ev, er;
        if (rst) begin
            ev = m_active && !m_stepwait && (m_age >= 3);
            er = m_active && !m_stepwait && (m_age == 1);
            check("instr_valid", bus.instr_valid, ev);
            check("imem_re", bus.imem_re, er);
            check("pc", pc, m_pc);
            check("halted", halted, m_halted);
            check("retired", retired, m_ret);
            if (er) check("imem_addr", bus.imem_addr, m_pc);
            if (ev) check("instr", bus.instr, rom[m_pc]);
            if (bus.instr_valid && bus.cu_ready) begin
                hs_count++;
                acc_q.push_back(bus.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; bus.cu_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic fill_rom_nonhalt();
        for (int i = 0; i < 32; i++) begin
            rom[i] = IW'($urandom);
            rom[i][19:18] = 2'($urandom_range(1, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_imem_addr"}, bus.imem_addr, 0);
        check({tag, "_imem_re"}, bus.imem_re, 0);
        check({tag, "_instr"}, bus.instr, 0);
        check({tag, "_instr_valid"}, bus.instr_valid, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_retired"}, retired, 0);
    endtask

    initial begin
        logic [IW-1:0] exp31 [3];
        logic [IW-1:0] hold_instr;
        logic [AB-1:0] hold_pc;
        int first, base, k;
        bit wrapped, seen31, got;

        for (int i = 0; i < 32; i++) rom[i] = '0;
        bus.cu_ready = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) tick();
        check_reset_outputs("idle_after_reset");

        // Three-word program ending on a halt word.
        exp31[0] = 20'h41230; exp31[1] = 20'h80010; exp31[2] = 20'h00000;
        for (int i = 0; i < 3; i++) rom[i] = exp31[i];
        acc_q.delete();
        bus.cu_ready = 1'b1;
        start = 1'b1;
        first = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = 1'b0;
            if (bus.instr_valid && first < 0) first = c;
            if (halted) break;
        end
        check("first_valid_cycle", first, 3);
        check("accepted_count", acc_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("accepted_word", (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hdead_beef, exp31[i]);
        check("prog_halted", halted, 1);
        check("prog_retired", retired, 3);
        check("prog_pc", pc, 2);

        // Instruction held while the CU is not ready.
        do_reset();
        fill_rom_nonhalt();
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            got = bus.instr_valid;
        end
        check("stall_reached_issue", got, 1);
        hold_instr = bus.instr;
        hold_pc = pc;
        check("stall_first_instr", hold_instr, rom[0]);
        check("stall_first_pc", hold_pc, 0);
        repeat (10) begin
            tick();
            check("stall_valid", bus.instr_valid, 1);
            check("stall_instr", bus.instr, hold_instr);
            check("stall_pc", pc, hold_pc);
            check("stall_re", bus.imem_re, 0);
        end

        // Long run without a halt word: pc wrap and retired saturation.
        do_reset();
        fill_rom_nonhalt();
        bus.cu_ready = 1'b1;
        base = hs_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        wrapped = 1'b0; seen31 = 1'b0; got = 1'b0;
        k = 0;
        while (!got && k < 400) begin
            tick();
            k++;
            if (pc == 5'd31) seen31 = 1'b1;
            if (seen31 && pc == 5'd0) wrapped = 1'b1;
            if (retired == 8'd40) got = 1'b1;
        end
        check("reach_retired_40", got, 1);
        check("pc_after_40", pc, 8);
        check("pc_wrapped", wrapped, 1);
        k = 0;
        while ((hs_count - base) < 300 && k < 3000) begin
            tick();
            k++;
        end
        check("handshakes_300", (hs_count - base) >= 300, 1);
        check("retired_saturated", retired, 255);

        // Reset arriving during WAIT.
        do_reset();
        fill_rom_nonhalt();
        bus.cu_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pre_rst_fetch_re", bus.imem_re, 1);
        tick();
        check("pre_rst_wait_re", bus.imem_re, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) begin
            tick();
            check("post_rst_valid", bus.instr_valid, 0);
            check("post_rst_re", bus.imem_re, 0);
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: nothing is fetched after a handshake until step is pulsed.
        do_reset();
        fill_rom_nonhalt();
        bus.cu_ready = 1'b1;
        base = hs_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while ((hs_count - base) < 1 && k < 20) begin
            tick();
            k++;
        end
        check("step_first_handshake", (hs_count - base) >= 1, 1);
        repeat (8) begin
            tick();
            check("step_wait_re", bus.imem_re, 0);
            check("step_wait_pc", pc, 1);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch_re", bus.imem_re, 1);
        check("step_fetch_addr", bus.imem_addr, 1);
        tick();
        check("step_single_fetch", bus.imem_re, 0);
`endif

        // Randomized traffic with occasional halts, restarts and resets.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            rom[i] = IW'($urandom);
            if ($urandom_range(0, 3) == 0) rom[i][19:18] = 2'b00;
        end
        for (int c = 0; c < 3000; c++) begin
            bus.cu_ready = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 15) == 0);
`ifdef SEQ_SINGLE_STEP_EN
            step = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have parameter INSTR_WIDTH, default 20, giving the instruction word width.
REQ-002 The module SHALL have parameter ADDR_BITS, default 5, giving the instruction-memory address width (32 words).
REQ-003 The module SHALL have parameter CNT_WIDTH, default 8, giving the retired-instruction counter width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: begin or restart execution from address 0.
REQ-007 The module SHALL have port imem_addr, output, ADDR_BITS: instruction-memory read address.
REQ-008 The module SHALL have port imem_re, output, 1 bit: instruction-memory read enable.
REQ-009 The module SHALL have port imem_data, input, INSTR_WIDTH: read data, valid exactly 1 cycle after imem_re.
REQ-010 The module SHALL have port instr, output, INSTR_WIDTH: instruction presented to the CU.
REQ-011 The module SHALL have port instr_valid, output, 1 bit: instr is valid.
REQ-012 The module SHALL have port cu_ready, input, 1 bit: the CU accepts instr (CU write-back complete).
REQ-013 The module SHALL have port pc, output, ADDR_BITS: address of the current or next instruction.
REQ-014 The module SHALL have port halted, output, 1 bit: a halt word has been retired.
REQ-015 The module SHALL have port retired, output, CNT_WIDTH: count of accepted instructions.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, WAIT, ISSUE and HALTED, with any other encoding returning to IDLE on the next edge.
REQ-017 In IDLE or HALTED, start=1 SHALL set pc=0, clear retired and halted, and go to FETCH; otherwise the state SHALL hold.
REQ-018 FETCH SHALL drive imem_re=1 and imem_addr=pc for exactly one cycle, then go to WAIT; imem_re SHALL be 0 in all other states.
REQ-019 WAIT SHALL register imem_data into instr and go to ISSUE, giving 3 cycles from start to first instr_valid.
REQ-020 In ISSUE, instr_valid SHALL be 1 and instr SHALL stay stable until cu_ready=1 is sampled at a rising edge.
REQ-021 On handshake, instr_valid SHALL drop the next cycle and retired SHALL increment, saturating at 2^CNT_WIDTH-1.
REQ-022 On handshake with instr[19:18]!=00, pc SHALL become pc+1 modulo 2^ADDR_BITS (31 wraps to 0) and the FSM SHALL go to FETCH.
REQ-023 On handshake with instr[19:18]==00 (halt word), pc SHALL hold, halted SHALL be set to 1, and the FSM SHALL go to HALTED.
REQ-024 cu_ready SHALL be ignored outside ISSUE, and start SHALL be ignored in FETCH, WAIT and ISSUE.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, pc=0, imem_addr=0, imem_re=0, instr=0, instr_valid=0, halted=0 and retired=0, including mid-fetch or mid-issue.
REQ-027 After rst deasserts, outputs SHALL stay at reset values until start is sampled high.

Configuration
REQ-028 Macro SEQ_SINGLE_STEP_EN SHALL control an added input step (1 bit) and a STEP state.
REQ-029 With SEQ_SINGLE_STEP_EN defined, a non-halt handshake SHALL go to STEP; STEP SHALL hold pc until step=1, then go to FETCH.
REQ-030 Without SEQ_SINGLE_STEP_EN, the step port and STEP state SHALL not exist, and behaviour SHALL be as REQ-022.

Verification
REQ-031 ROM[0..2]={0x4_1230, 0x8_0010, 0x0_0000}, cu_ready=1, pulse start -> instr_valid first high cycle 3, then 0x41230, 0x80010, 0x00000 accepted in order, halted=1, retired=3, pc=2.
REQ-032 cu_ready held 0 for 10 cycles in ISSUE -> instr_valid stays 1, instr unchanged, pc unchanged, imem_re stays 0.
REQ-033 ROM with no halt word, cu_ready=1, 40 instructions -> pc wraps 31->0, retired=40.
REQ-034 300 non-halt instructions accepted -> retired saturates at 255.
REQ-035 rst=0 asserted during WAIT -> all outputs at reset values immediately, with no instr_valid until a new start.
REQ-036 With SEQ_SINGLE_STEP_EN, after the first handshake -> no imem_re until step=1, then one fetch at pc=1.
